// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU engine producing the {hi, low} pair.
//
// An operation is accepted on in_valid & allow_in. It is computed iteratively:
// shift-add for multiply, restoring division for divide. Both work on operand
// magnitudes, and the sign fix-up happens when the result registers are
// written. The result is then held on hi/low with out_valid until
// out_valid & out_ready.
//
// Optional feature macro: MDU_FAST_MUL_EN. When defined, multiplies use a
// single-cycle WIDTH x WIDTH multiplier and out_valid rises 2 edges after the
// transfer. Divides are unchanged.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   operation request valid
//   allow_in   out  unit can accept an operation this cycle
//   op         in   one-hot {DIVU, DIV, MULTU, MULT}, sampled on transfer
//   src1       in   multiplicand / dividend
//   src2       in   multiplier / divisor
//   cancel     in   flush any in-flight operation, block transfer
//   busy       out  operation accepted and result not yet consumed
//   out_valid  out  hi/low valid
//   out_ready  in   consumer takes result when out_valid & out_ready
//   hi         out  MULT: product upper half; DIV: remainder
//   low        out  MULT: product lower half; DIV: quotient

module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             allow_in,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] low
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    // Counter load value. The iteration steps run while the counter is
    // non-zero. One extra cycle at zero applies the sign fix-up and enters
    // StDone.
    localparam logic [CNT_W-1:0] DivIters = CNT_W'(WIDTH);
`ifdef MDU_FAST_MUL_EN
    localparam logic [CNT_W-1:0] MulIters = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] MulIters = CNT_W'(WIDTH);
`endif

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiply: multiplicand magnitude. Divide: divisor magnitude.
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 neg_lo_q, neg_lo_d;   // negate product / quotient
    logic                 neg_hi_q, neg_hi_d;   // negate remainder
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     low_q, low_d;

    // Input decode
    logic             transfer;
    logic             op_div;
    logic             op_signed;
    logic             s1_neg, s2_neg;
    logic [WIDTH-1:0] mag1, mag2;

    // Datapath
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign allow_in  = ~cancel & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    assign transfer  = in_valid & allow_in;
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign hi        = hi_q;
    assign low       = low_q;

    // Any op[3:2] bit selects the divider, so a malformed op still lands
    // in a legal state.
    assign op_div    = op[3] | op[2];
    assign op_signed = op_div ? (op[2] & ~op[3]) : (op[0] & ~op[1]);
    assign s1_neg    = op_signed & src1[WIDTH-1];
    assign s2_neg    = op_signed & src2[WIDTH-1];
    assign mag1      = s1_neg ? -src1 : src1;
    assign mag2      = s2_neg ? -src2 : src2;

`ifdef MDU_FAST_MUL_EN
    assign mul_step = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
    logic [WIDTH:0] mul_sum;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    // Restoring step: trial-subtract the divisor from the remainder shifted
    // one bit left. The trial succeeds when the borrow bit is clear. With a
    // zero divisor, every trial succeeds. The quotient then becomes all ones
    // and the remainder becomes the dividend.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    assign div_ok    = ~div_trial[WIDTH];
    assign div_step  = {div_ok ? div_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1],
                        acc_q[WIDTH-2:0], div_ok};

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix  = div_zero_q ? '1 :
                      (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        low_d      = low_q;

        unique case (state_q)
            StIdle: ;
            StMul: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                    low_d   = prod_fix[WIDTH-1:0];
                end else begin
                    acc_d = mul_step;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDiv: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    hi_d    = rem_fix;
                    low_d   = quo_fix;
                end else begin
                    acc_d = div_step;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A transfer can only occur from StIdle, or from StDone while the
        // result is being consumed. It overrides the return to StIdle.
        if (transfer) begin
            if (op_div) begin
                state_d    = StDiv;
                cnt_d      = DivIters;
                acc_d      = {{WIDTH{1'b0}}, mag1};
                b_d        = mag2;
                neg_lo_d   = s1_neg ^ s2_neg;
                neg_hi_d   = s1_neg;
                div_zero_d = (src2 == '0);
            end else begin
                state_d    = StMul;
                cnt_d      = MulIters;
                acc_d      = {{WIDTH{1'b0}}, mag2};
                b_d        = mag1;
                neg_lo_d   = s1_neg ^ s2_neg;
                neg_hi_d   = 1'b0;
                div_zero_d = 1'b0;
            end
        end

        // Cancel wins over everything, including the result write on
        // StDone entry.
        if (cancel) begin
            state_d = StIdle;
            hi_d    = hi_q;
            low_d   = low_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            low_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            low_q      <= low_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (WIDTH = 32).
// Honours MDU_FAST_MUL_EN for the expected multiply latency.

module tb_mul_div_unit;

    localparam logic [3:0] OpMult  = 4'b0001;
    localparam logic [3:0] OpMultu = 4'b0010;
    localparam logic [3:0] OpDiv   = 4'b0100;
    localparam logic [3:0] OpDivu  = 4'b1000;
    localparam int DivLat = 33;
`ifdef MDU_FAST_MUL_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = 33;
`endif

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        allow_in;
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        cancel;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] low;

    int n_checks;
    int n_fail;

    mul_div_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .allow_in (allow_in),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .cancel   (cancel),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .hi       (hi),
        .low      (low)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present an op until accepted. Returns #1 after the transfer edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (allow_in) break;
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges after the transfer until out_valid is seen; 0 means timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks += 5;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        if (hi !== 32'h0) begin
            n_fail++; $display("FAIL reset_hi: got %h want 0", hi);
        end
        if (low !== 32'h0) begin
            n_fail++; $display("FAIL reset_low: got %h want 0", low);
        end
        if (allow_in !== 1'b1) begin
            n_fail++; $display("FAIL reset_allow_in: got %b want 1", allow_in);
        end
    endtask

    task automatic test_mult();
        int lat;
        issue(OpMult, 32'hFFFF_FFFD, 32'd5);
        n_checks += 5;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mult_busy: got %b want 1", busy);
        end
        if (allow_in !== 1'b0) begin
            n_fail++; $display("FAIL mult_allow_in: got %b want 0", allow_in);
        end
        wait_valid(lat);
        if (lat != MulLat) begin
            n_fail++; $display("FAIL mult_latency: got %0d want %0d", lat, MulLat);
        end
        if (hi !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi);
        end
        if (low !== 32'hFFFF_FFF1) begin
            n_fail++; $display("FAIL mult_low: got %h want fffffff1", low);
        end
    endtask

    task automatic test_multu();
        int lat;
        issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(lat);
        n_checks += 3;
        if (lat != MulLat) begin
            n_fail++; $display("FAIL multu_latency: got %0d want %0d", lat, MulLat);
        end
        if (hi !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi);
        end
        if (low !== 32'h0000_0001) begin
            n_fail++; $display("FAIL multu_low: got %h want 00000001", low);
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops[5];
        logic [31:0] a[5], b[5], eh[5], el[5];
        int lat;
        ops[0] = OpDiv;  a[0] = 32'hFFFF_FFF9; b[0] = 32'd2;         eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFFD;
        ops[1] = OpDivu; a[1] = 32'd7;         b[1] = 32'd2;         eh[1] = 32'd1;         el[1] = 32'd3;
        ops[2] = OpDiv;  a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF; eh[2] = 32'd0;         el[2] = 32'h8000_0000;
        ops[3] = OpDiv;  a[3] = 32'd7;         b[3] = 32'hFFFF_FFFE; eh[3] = 32'd1;         el[3] = 32'hFFFF_FFFD;
        ops[4] = OpDivu; a[4] = 32'hFFFF_FFFF; b[4] = 32'd16;        eh[4] = 32'd15;        el[4] = 32'h0FFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], a[i], b[i]);
            wait_valid(lat);
            n_checks += 3;
            if (lat != DivLat) begin
                n_fail++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, DivLat);
            end
            if (hi !== eh[i]) begin
                n_fail++; $display("FAIL div%0d_hi: got %h want %h", i, hi, eh[i]);
            end
            if (low !== el[i]) begin
                n_fail++; $display("FAIL div%0d_low: got %h want %h", i, low, el[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [31:0] eh[2], el[2], a[2];
        logic [3:0]  ops[2];
        ops[0] = OpDivu; a[0] = 32'd7;         eh[0] = 32'd7;         el[0] = 32'hFFFF_FFFF;
        ops[1] = OpDiv;  a[1] = 32'hFFFF_FFF0; eh[1] = 32'hFFFF_FFF0; el[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], a[i], 32'd0);
            wait_valid(lat);
            n_checks += 3;
            if (lat != DivLat) begin
                n_fail++; $display("FAIL divzero%0d_latency: got %0d want %0d", i, lat, DivLat);
            end
            if (hi !== eh[i]) begin
                n_fail++; $display("FAIL divzero%0d_hi: got %h want %h", i, hi, eh[i]);
            end
            if (low !== el[i]) begin
                n_fail++; $display("FAIL divzero%0d_low: got %h want %h", i, low, el[i]);
            end
        end
    endtask

    task automatic test_cancel();
        bit seen;
        issue(OpDiv, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        cancel = 1'b1;
        #1;
        n_checks += 5;
        if (allow_in !== 1'b0) begin
            n_fail++; $display("FAIL cancel_allow_in_during: got %b want 0", allow_in);
        end
        @(posedge clock);
        #1;
        cancel = 1'b0;
        #1;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL cancel_busy: got %b want 0", busy);
        end
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL cancel_out_valid: got %b want 0", out_valid);
        end
        if (allow_in !== 1'b1) begin
            n_fail++; $display("FAIL cancel_allow_in_after: got %b want 1", allow_in);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL cancel_no_result: out_valid seen %b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit held_bad;
        out_ready = 1'b0;
        issue(OpMult, 32'd3, 32'd4);
        wait_valid(lat);
        n_checks += 10;
        if (lat != MulLat) begin
            n_fail++; $display("FAIL b2b_mult_latency: got %0d want %0d", lat, MulLat);
        end
        if (hi !== 32'd0 || low !== 32'd12) begin
            n_fail++; $display("FAIL b2b_mult_result: got %h_%h want 00000000_0000000c", hi, low);
        end
        held_bad = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (out_valid !== 1'b1 || hi !== 32'd0 || low !== 32'd12) held_bad = 1'b1;
        end
        if (held_bad !== 1'b0) begin
            n_fail++; $display("FAIL b2b_hold: result not held, got %b want 0", held_bad);
        end
        if (allow_in !== 1'b0) begin
            n_fail++; $display("FAIL b2b_allow_in_stalled: got %b want 0", allow_in);
        end
        out_ready = 1'b1;
        #1;
        if (allow_in !== 1'b1) begin
            n_fail++; $display("FAIL b2b_allow_in_ready: got %b want 1", allow_in);
        end
        issue(OpDivu, 32'd9, 32'd4);
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_out_valid_after: got %b want 0", out_valid);
        end
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_busy_after: got %b want 1", busy);
        end
        wait_valid(lat);
        if (lat != DivLat) begin
            n_fail++; $display("FAIL b2b_divu_latency: got %0d want %0d", lat, DivLat);
        end
        if (low !== 32'd2) begin
            n_fail++; $display("FAIL b2b_divu_low: got %h want 2", low);
        end
        if (hi !== 32'd1) begin
            n_fail++; $display("FAIL b2b_divu_hi: got %h want 1", hi);
        end
    endtask

    task automatic test_reset_mid_op();
        issue(OpMultu, 32'd5, 32'd6);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        n_checks += 4;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_busy: got %b want 0", busy);
        end
        if (hi !== 32'd0 || low !== 32'd0) begin
            n_fail++; $display("FAIL midreset_result: got %h_%h want 0_0", hi, low);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_idle: got %b want 0", busy);
        end
        if (allow_in !== 1'b1) begin
            n_fail++; $display("FAIL midreset_allow_in: got %b want 1", allow_in);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'b0;
        src1      = 32'h0;
        src2      = 32'h0;
        cancel    = 1'b0;
        out_ready = 1'b1;
        #12;
        test_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
